// File: rtl/spi_txn_scheduler.sv
// Sequences SPI-decoded register transactions onto a shared module bus:
// queued writes, prioritised reads, and a per-transaction timeout.
module spi_txn_scheduler #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_MODULES = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                              i_CLK,
    input  logic                              i_RST,
    input  logic                              i_WR_VALID,
    input  logic                              i_RD_REQ,
    input  logic [ADDR_WIDTH-1:0]             i_ADDR,
    input  logic [DATA_WIDTH-1:0]             i_WDATA,
    input  logic                              i_CLR_ERR,
    input  logic [NUM_MODULES-1:0]            i_ACK,
    input  logic [NUM_MODULES*DATA_WIDTH-1:0] i_RDATA,
    output logic [NUM_MODULES-1:0]            o_SEL,
    output logic [ADDR_WIDTH-4:0]             o_REG_ADDR,
    output logic [DATA_WIDTH-1:0]             o_WDATA,
    output logic                              o_WE,
    output logic                              o_RE,
    output logic [DATA_WIDTH-1:0]             o_RDATA,
    output logic                              o_FIFO_FULL,
    output logic                              o_DROP,
    output logic                              o_TIMEOUT
);
    localparam int RW = ADDR_WIDTH - 3;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                  state_q, state_d;
    logic [NUM_MODULES-1:0]  sel_q, sel_d;
    logic [RW-1:0]           reg_addr_q, reg_addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    we_q, we_d, re_q, re_d;
    logic                    vld_q, vld_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    drop_q, drop_d, tmo_q, tmo_d;
    logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   fa_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fd_q [FIFO_DEPTH];

    logic                    full, push, pop, hit, expire, fin;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic [DATA_WIDTH-1:0]   head_data, rsel;
    logic [NUM_MODULES-1:0]  ent_sel;

    function automatic logic [NUM_MODULES-1:0] dec(input logic [2:0] idx);
        logic [NUM_MODULES-1:0] oh;
        for (int k = 0; k < NUM_MODULES; k++) oh[k] = (idx == 3'(k));
        return oh;
    endfunction

    always_comb begin
        rsel = '0;
        for (int k = 0; k < NUM_MODULES; k++)
            if (sel_q[k]) rsel = i_RDATA[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign head_addr = fa_q[rp_q];
    assign head_data = fd_q[rp_q];
    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign push      = i_WR_VALID && !full;
    assign hit       = |(i_ACK & sel_q);
    // An ack on the last allowed cycle beats the timeout.
    assign expire    = vld_q && !hit && (tcnt_q == TW'(TIMEOUT - 1));
    assign fin       = (state_q != IDLE) && (!vld_q || hit || expire);
    assign pop       = fin && (state_q == WRITE);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        we_d       = we_q;
        re_d       = re_q;
        vld_d      = vld_q;
        tcnt_d     = tcnt_q;
        rd_pend_d  = rd_pend_q;
        rd_addr_d  = rd_addr_q;
        drop_d     = drop_q;
        tmo_d      = tmo_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        ent_sel    = '0;

        if (i_CLR_ERR) begin
            drop_d = 1'b0;
            tmo_d  = 1'b0;
        end
        if (i_WR_VALID && full) drop_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (rd_pend_q) begin
                    ent_sel    = dec(rd_addr_q[2:0]);
                    state_d    = READ;
                    rd_pend_d  = 1'b0;
                    sel_d      = ent_sel;
                    re_d       = |ent_sel;
                    vld_d      = |ent_sel;
                    reg_addr_d = rd_addr_q[ADDR_WIDTH-1:3];
                    tcnt_d     = '0;
                end else if (cnt_q != '0) begin
                    ent_sel    = dec(head_addr[2:0]);
                    state_d    = WRITE;
                    sel_d      = ent_sel;
                    we_d       = |ent_sel;
                    vld_d      = |ent_sel;
                    reg_addr_d = head_addr[ADDR_WIDTH-1:3];
                    wdata_d    = head_data;
                    tcnt_d     = '0;
                end
            end
            READ, WRITE: begin
                if (fin) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    sel_d   = '0;
                    if (state_q == READ) rdata_d = expire ? '1 : rsel;
                    if (expire) tmo_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Latest read request wins; the bus copy lives in reg_addr_q.
        if (i_RD_REQ) begin
            rd_pend_d = 1'b1;
            rd_addr_d = i_ADDR;
        end

        if (push) wp_d = wp_q + PW'(1);
        if (pop)  rp_d = rp_q + PW'(1);
    end

    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            reg_addr_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            vld_q      <= 1'b0;
            tcnt_q     <= '0;
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= '0;
            drop_q     <= 1'b0;
            tmo_q      <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            vld_q      <= vld_d;
            tcnt_q     <= tcnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_addr_q  <= rd_addr_d;
            drop_q     <= drop_d;
            tmo_q      <= tmo_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (push) begin
            fa_q[wp_q] <= i_ADDR;
            fd_q[wp_q] <= i_WDATA;
        end
    end

    assign o_SEL       = sel_q;
    assign o_REG_ADDR  = reg_addr_q;
    assign o_WDATA     = wdata_q;
    assign o_WE        = we_q;
    assign o_RE        = re_q;
    assign o_RDATA     = rdata_q;
    assign o_FIFO_FULL = full;
    assign o_DROP      = drop_q;
    assign o_TIMEOUT   = tmo_q;
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Scoreboard bench for spi_txn_scheduler: expected bus transactions are
// queued by the stimulus and matched by an independent bus monitor.
module tb_spi_txn_scheduler;
    localparam int AW = 13;
    localparam int DW = 16;
    localparam int NM = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid, rd_req, clr;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    logic [NM-1:0]    ack = '0;
    logic [NM*DW-1:0] rdata_bus;
    logic [NM-1:0]    sel;
    logic [AW-4:0]    reg_addr;
    logic [DW-1:0]    o_wdata, o_rdata;
    logic             we, re, full, drop, tmo;

    typedef struct {
        logic          we;
        logic [NM-1:0] sel;
        logic [9:0]    ra;
        logic [15:0]   wd;
        int            len;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   ack_lat = 1;
    bit   ack_en = 1'b0;
    int   scnt = 0;
    int   mlen = 0;
    int   ntx = 0;
    bit   prev = 1'b0;

    assign rdata_bus = {16'h1234, 16'h4444, 16'h3333,
                        16'h2222, 16'hA5A5, 16'h0F0F};

    spi_txn_scheduler #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MODULES(NM),
        .FIFO_DEPTH(4), .TIMEOUT(255)
    ) dut (
        .i_CLK(clk), .i_RST(rst), .i_WR_VALID(wr_valid),
        .i_RD_REQ(rd_req), .i_ADDR(addr), .i_WDATA(wdata),
        .i_CLR_ERR(clr), .i_ACK(ack), .i_RDATA(rdata_bus),
        .o_SEL(sel), .o_REG_ADDR(reg_addr), .o_WDATA(o_wdata),
        .o_WE(we), .o_RE(re), .o_RDATA(o_rdata),
        .o_FIFO_FULL(full), .o_DROP(drop), .o_TIMEOUT(tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic w, input logic [NM-1:0] s,
                                input logic [9:0] r, input logic [15:0] d,
                                input int l);
        exp_t e;
        e.we = w; e.sel = s; e.ra = r; e.wd = d; e.len = l;
        return e;
    endfunction

    // Module model: acks the selected module after ack_lat strobe cycles.
    always @(negedge clk) begin
        if (we || re) scnt = scnt + 1;
        else scnt = 0;
        ack = (ack_en && (we || re) && scnt >= ack_lat) ? sel : '0;
    end

    // Bus monitor: matches each strobe against the scoreboard.
    always @(negedge clk) begin
        if ((we || re) && !prev) begin
            ntx++;
            mlen = 1;
            if (sb.size() == 0) begin
                total++;
                bad++;
                cur.len = 0;
                $display("FAIL unexpected_txn: sel=%h we=%b re=%b want none",
                         sel, we, re);
            end else begin
                cur = sb.pop_front();
                check("txn_we", 32'(we), 32'(cur.we));
                check("txn_re", 32'(re), 32'(!cur.we));
                check("txn_sel", 32'(sel), 32'(cur.sel));
                check("txn_reg", 32'(reg_addr), 32'(cur.ra));
                if (cur.we) check("txn_wdata", 32'(o_wdata), 32'(cur.wd));
            end
        end else if (we || re) begin
            mlen++;
        end else if (prev && cur.len != 0) begin
            check("txn_len", 32'(mlen), 32'(cur.len));
        end
        prev = we || re;
    end

    task automatic push(input logic [AW-1:0] a, input logic [15:0] d);
        wr_valid = 1'b1;
        addr = a;
        wdata = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_req = 1'b1;
        addr = a;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic clr_err();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        bit ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (sb.size() == 0 && !we && !re) ok = 1'b1;
        end
        check({"idle_", nm}, 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: sim time exceeded, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst = 1'b1; wr_valid = 1'b0; rd_req = 1'b0; clr = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_re", 32'(re), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_rdata", 32'(o_rdata), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wdata", 32'(o_wdata), 32'd0);

        // T1: single write, ack on the third strobe cycle
        ack_en = 1'b1; ack_lat = 3;
        sb.push_back(mk(1'b1, 6'h04, 10'd10, 16'hBEEF, 3));
        push(13'h0052, 16'hBEEF);
        wait_idle(50, "t1");
        check("t1_full", 32'(full), 32'd0);

        // T2: read overtakes queued writes
        ack_lat = 4;
        sb.push_back(mk(1'b1, 6'h01, 10'd1, 16'h1111, 4));
        sb.push_back(mk(1'b0, 6'h20, 10'd7, 16'h0000, 4));
        sb.push_back(mk(1'b1, 6'h08, 10'd2, 16'h2222, 4));
        sb.push_back(mk(1'b1, 6'h10, 10'd3, 16'h3333, 4));
        push(13'h0008, 16'h1111);
        push(13'h0013, 16'h2222);
        push(13'h001C, 16'h3333);
        rd(13'h003D);
        wait_idle(100, "t2");
        check("t2_rdata", 32'(o_rdata), 32'h1234);

        // T3: overflow with acks stalled
        ack_en = 1'b0; ack_lat = 1;
        sb.push_back(mk(1'b1, 6'h02, 10'd1, 16'hA001, 0));
        sb.push_back(mk(1'b1, 6'h04, 10'd2, 16'hA002, 1));
        sb.push_back(mk(1'b1, 6'h08, 10'd3, 16'hA003, 1));
        sb.push_back(mk(1'b1, 6'h10, 10'd4, 16'hA004, 1));
        push(13'h0009, 16'hA001);
        push(13'h0012, 16'hA002);
        push(13'h001B, 16'hA003);
        check("t3_full3", 32'(full), 32'd0);
        push(13'h0024, 16'hA004);
        check("t3_full4", 32'(full), 32'd1);
        check("t3_drop4", 32'(drop), 32'd0);
        push(13'h0028, 16'hA005);
        check("t3_drop5", 32'(drop), 32'd1);
        check("t3_full5", 32'(full), 32'd1);
        ack_en = 1'b1;
        wait_idle(100, "t3");
        check("t3_full_end", 32'(full), 32'd0);
        check("t3_drop_sticky", 32'(drop), 32'd1);
        clr_err();
        check("t3_drop_clr", 32'(drop), 32'd0);

        // T4: read timeout
        ack_en = 1'b0;
        sb.push_back(mk(1'b0, 6'h02, 10'd4, 16'h0000, 255));
        rd(13'h0021);
        wait_idle(400, "t4");
        check("t4_rdata", 32'(o_rdata), 32'hFFFF);
        check("t4_tmo", 32'(tmo), 32'd1);
        clr_err();
        check("t4_tmo_clr", 32'(tmo), 32'd0);

        // T5: reset during a write
        sb.push_back(mk(1'b1, 6'h04, 10'd5, 16'hCAFE, 0));
        push(13'h002A, 16'hCAFE);
        push(13'h0033, 16'hD00D);
        repeat (2) @(negedge clk);
        check("t5_we_pre", 32'(we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_we_async", 32'(we), 32'd0);
        check("t5_sel_async", 32'(sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("t5_rdata", 32'(o_rdata), 32'd0);
        check("t5_full", 32'(full), 32'd0);
        ack_en = 1'b1; ack_lat = 1;
        n0 = ntx;
        repeat (20) @(negedge clk);
        check("t5_no_txn", 32'(ntx - n0), 32'd0);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // T6: invalid module, then ack racing the timeout
        sb.push_back(mk(1'b0, 6'h20, 10'd0, 16'h0000, 1));
        rd(13'h0005);
        wait_idle(50, "t6a");
        check("t6_rdata_pre", 32'(o_rdata), 32'h1234);
        rd(13'h0007);
        @(negedge clk);
        check("t6_rdata_hold", 32'(o_rdata), 32'h1234);
        check("t6_sel_none", 32'(sel), 32'd0);
        check("t6_re_none", 32'(re), 32'd0);
        @(negedge clk);
        check("t6_rdata_inv", 32'(o_rdata), 32'd0);
        check("t6_tmo_inv", 32'(tmo), 32'd0);
        ack_lat = 255;
        sb.push_back(mk(1'b0, 6'h02, 10'd4, 16'h0000, 255));
        rd(13'h0021);
        wait_idle(400, "t6b");
        check("t6_rdata_race", 32'(o_rdata), 32'hA5A5);
        check("t6_tmo_race", 32'(tmo), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
